if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction fetch stage for the RV32 core. It holds the PC and issues one-outstanding-request reads to instruction memory, and buffers returned words in a 1-entry skid buffer. It presents instructions through the IF/ID register to decode, where `if_id_opcode` drives the control unit. It honours decode stalls and execute-stage redirects (JAL/branch), and can optionally predecode JAL to redirect early.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value `if_id_instr` holds when invalid (`addi x0,x0,0`).

Ports:
- `clk` in 1: clock. One clock; all state on the rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch address, equal to `pc`.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: read data valid.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: execute-stage PC redirect.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `id_stall` in 1: decode cannot accept a new instruction this cycle.
- `if_id_valid` out 1: IF/ID register holds a live instruction.
- `if_id_instr` out 32: instruction word.
- `if_id_pc` out 32: address of `if_id_instr`.
- `if_id_opcode` out 7: `if_id_instr[6:0]`, combinational from the register.
- `if_id_pred_taken` out 1: instruction was redirected by predecode.

## Operation
- Registers: `pc`, `req_pc`, `state` in {REQ, WAIT, DROP}, skid entry (valid, instr, pc, pred), IF/ID entry.
- Request handshake:
  - `imem_req_valid = (state==REQ) && !skid_valid && !rst`.
  - The request is accepted on `imem_req_valid && imem_req_ready`; then `req_pc<=pc`, `pc<=pc+4` (mod 2^32, wraps 32'hFFFF_FFFC -> 0), and the state goes to WAIT.
- Response:
  - In WAIT, `imem_rsp_valid` returns to REQ with word W at `req_pc`.
  - In REQ, `imem_rsp_valid` is ignored.
  - In DROP, the response is discarded and the state returns to REQ.
- IF/ID is consumed when `if_id_valid && !id_stall`. IF/ID is free when it is consumed or `!if_id_valid`.
- Fill priority when IF/ID is free: skid entry first, else W; otherwise W goes to the skid buffer. Skid and W never both arrive while the skid is full, because no request is issued while the skid is valid.
- Invalid IF/ID: `if_id_instr=NOP_INSTR`, and `if_id_pc`/`if_id_pred_taken` hold their previous values.
- Redirect has the highest priority:
  - It clears IF/ID valid and skid valid, and sets `pc<=redirect_pc`.
  - State after redirect: WAIT and no response this cycle -> DROP; WAIT with response this cycle -> REQ (response discarded); REQ with a request accepted this cycle -> DROP; otherwise -> REQ.
  - Redirect overrides `id_stall` and predecode.
- Reset mid-operation: all state is forced immediately. Any in-flight memory response after reset is ignored, since the state is REQ.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `if_id_valid=0`, `if_id_instr=NOP_INSTR`, `if_id_pc=0`, `if_id_pred_taken=0`; `state=REQ`, skid empty.
- First request is visible in the first cycle after `rst` deasserts.
- Latency from response to `if_id_valid`: 1 cycle (registered).
- With a zero-wait memory (response the cycle after acceptance): one instruction per 2 cycles. Single outstanding request is by design.
- A redirect at edge N puts `redirect_pc` on `imem_req_addr` in cycle N+1, unless the state is DROP.
- `id_stall` high holds IF/ID contents unchanged.

## Configuration
- `IF_JAL_PREDECODE_EN` defined:
  - Any W with `W[6:0]==7'b1101111` accepted in WAIT (not DROP, no redirect) sets `pc <= req_pc + sext({W[31],W[19:12],W[20],W[30:21],1'b0})` and marks the entry `pred=1`.
  - Execute still raises `redirect_valid` for JAL. The team's hazard logic suppresses that redirect when `if_id_pred_taken` travelled with the instruction; this block does not check it.
- Not defined: no predecode, `pc` is always +4, and `if_id_pred_taken` is tied 0.

## Test plan
- Reset with `RESET_PC=32'h100` and a zero-wait memory returning `32'h00500093` -> first request addr 32'h100. Then IF/ID valid with instr 32'h00500093, pc 32'h100, opcode 7'b0010011; next request addr 32'h104.
- Hold `id_stall` for 5 cycles with IF/ID full -> one extra word lands in the skid, `imem_req_valid=0`, and IF/ID is unchanged. After release, the skid word moves into IF/ID on the next edge with no loss or duplicate.
- `redirect_valid` with `redirect_pc=32'h200` while in WAIT and the response is 3 cycles late -> the stale response is dropped, the next request addr is 32'h200, and IF/ID is invalid until the 0x200 word returns.
- `redirect_valid` in the same cycle as a response -> the response is discarded and the next request goes to the redirect target.
- `pc=32'hFFFF_FFFC` accepted -> next request addr 32'h0000_0000.
- With `IF_JAL_PREDECODE_EN`: at pc 32'h40, W=32'h0100006F (jal x0,+16) -> next request addr 32'h50 and `if_id_pred_taken=1`. Without the macro: next request addr 32'h44 and `if_id_pred_taken=0`.

Source files
------------

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32 fetch stage: single-outstanding imem reads, 1-entry skid, IF/ID register
// Optional early JAL redirect from predecode: define IF_JAL_PREDECODE_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [6:0]  if_id_opcode,
    output logic        if_id_pred_taken
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_pred_q, skid_pred_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_pred_q, ifid_pred_d;

    logic        req_fire;
    logic        rsp_take;
    logic        ifid_free;
    logic        w_pred;
    logic [31:0] w_target;

    assign imem_req_valid = (state_q == S_REQ) && !skid_valid_q && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = (state_q == S_WAIT) && imem_rsp_valid;
    assign ifid_free      = !ifid_valid_q || !id_stall;

`ifdef IF_JAL_PREDECODE_EN
    assign w_pred   = (imem_rsp_data[6:0] == 7'b1101111);
    assign w_target = req_pc_q + {{11{imem_rsp_data[31]}}, imem_rsp_data[31], imem_rsp_data[19:12],
                                  imem_rsp_data[20], imem_rsp_data[30:21], 1'b0};
`else
    assign w_pred   = 1'b0;
    assign w_target = req_pc_q + 32'd4;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pred_d  = skid_pred_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pred_d  = ifid_pred_q;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end
            end
            S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
            S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase

        if (rsp_take && w_pred) pc_d = w_target;

        // A held skid word is always older than any new response, so it drains first.
        if (ifid_free) begin
            if (skid_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr_q;
                ifid_pc_d    = skid_pc_q;
                ifid_pred_d  = skid_pred_q;
                skid_valid_d = 1'b0;
            end else if (rsp_take) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rsp_data;
                ifid_pc_d    = req_pc_q;
                ifid_pred_d  = w_pred;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end else if (rsp_take) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rsp_data;
            skid_pc_d    = req_pc_q;
            skid_pred_d  = w_pred;
        end

        // A request still in flight after a redirect must have its response swallowed in DROP.
        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = {redirect_pc[31:2], 2'b00};
            if ((state_q == S_WAIT && !imem_rsp_valid) || (state_q == S_REQ && req_fire))
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            skid_pred_q  <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pred_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pred_q  <= skid_pred_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pred_q  <= ifid_pred_d;
        end
    end

    assign if_id_valid      = ifid_valid_q;
    assign if_id_instr      = ifid_valid_q ? ifid_instr_q : NOP_INSTR;
    assign if_id_pc         = ifid_pc_q;
    assign if_id_opcode     = if_id_instr[6:0];
    assign if_id_pred_taken = ifid_pred_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_JAL_PREDECODE_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [6:0]  if_id_opcode;
    logic        if_id_pred_taken;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_opcode(if_id_opcode), .if_id_pred_taken(if_id_pred_taken)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program image: a hashed word per address, with occasional forward JALs.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [31:0] w;
        if (a == 32'h0000_0100) return 32'h0050_0093;
        if (a == 32'h0000_0040) return 32'h0100_006F;
        h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        if (h[2:0] == 3'd0) return {1'b0, 3'b000, h[8:3], 1'b0, 1'b0, 8'h00, 5'd1, 7'h6F};
        w = h;
        if (w[6:0] == 7'h6F) w[6:0] = 7'h33;
        return w;
    endfunction

    function automatic logic [31:0] jal_off(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // Reference model: the program-order stream decode should see.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] next_seq;

    task automatic sb_push_next();
        exp_t e;
        e.pc    = next_seq;
        e.instr = mem_word(next_seq);
        e.pred  = PRED_EN && (e.instr[6:0] == 7'h6F);
        sb_q.push_back(e);
        next_seq = e.pred ? next_seq + jal_off(e.instr) : next_seq + 32'd4;
    endtask

    task automatic sb_restart(input logic [31:0] t);
        sb_q.delete();
        next_seq = {t[31:2], 2'b00};
        sb_push_next();
    endtask

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (if_id_valid) begin
                chk("ifid_pc", if_id_pc, sb_q[0].pc);
                chk("ifid_instr", if_id_instr, sb_q[0].instr);
                chk("ifid_opcode", {25'd0, if_id_opcode}, {25'd0, sb_q[0].instr[6:0]});
                chk("ifid_pred", {31'd0, if_id_pred_taken}, {31'd0, sb_q[0].pred});
            end else begin
                chk("ifid_nop", if_id_instr, NOP);
            end
            if (redirect_valid) sb_restart(redirect_pc);
            else if (if_id_valid && !id_stall) begin
                void'(sb_q.pop_front());
                sb_push_next();
            end
        end
    end

    // Memory / stimulus driver state
    bit          pend = 1'b0;
    bit          stale = 1'b0;
    bit          acc_s, rsp_s;
    bit          rnd = 1'b0;
    bit          dir_stall = 1'b0;
    int          lat = 0;
    int          lat_force = 0;
    int          acc_cnt = 0;
    logic [31:0] paddr, acc_addr;

    task automatic step();
        @(negedge clk);
        acc_s    = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp_s    = imem_rsp_valid;
        if (redirect_valid && ((pend && !rsp_s) || acc_s)) stale = 1'b1;
        @(posedge clk);
        #1;
        if (rsp_s) begin
            imem_rsp_valid = 1'b0;
            pend  = 1'b0;
            stale = 1'b0;
        end
        if (acc_s) begin
            pend  = 1'b1;
            paddr = acc_addr;
            acc_cnt++;
            lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        end
        if (pend && !imem_rsp_valid) begin
            if (lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
            end else begin
                lat--;
            end
        end
        if (rnd) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_stall       = ($urandom_range(0, 3) == 0);
            redirect_valid = !stale && ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : 32'($urandom_range(0, 1023));
        end else begin
            imem_req_ready = 1'b1;
            id_stall       = dir_stall;
            redirect_valid = 1'b0;
        end
    endtask

    task automatic redirect_idle(input logic [31:0] t);
        int n = 0;
        while ((pend || stale) && n < 20) begin
            step();
            n++;
        end
        chk("idle_wait", {31'd0, pend}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        imem_req_ready = 1'b0;
        step();
    endtask

    initial begin
        int a0;
        int n;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_stall       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("rst_ifid_instr", if_id_instr, NOP);
        chk("rst_ifid_pc", if_id_pc, 32'd0);
        chk("rst_pred", 32'(if_id_pred_taken), 32'd0);

        sb_restart(RST_PC);
        imem_req_ready = 1'b1;
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h100);

        step();
        step();
        chk("zw_ifid_valid", 32'(if_id_valid), 32'd1);
        chk("zw_ifid_instr", if_id_instr, 32'h0050_0093);
        chk("zw_ifid_pc", if_id_pc, 32'h100);
        chk("zw_opcode", 32'(if_id_opcode), 32'h13);
        chk("zw_next_addr", imem_req_addr, 32'h104);

        a0 = acc_cnt;
        repeat (20) step();
        chk("zw_throughput", 32'(acc_cnt - a0), 32'd10);

        // Stall with IF/ID full: one word lands in the skid, then requests stop.
        chk("stall_pre_pc", if_id_pc, 32'h128);
        dir_stall = 1'b1;
        id_stall  = 1'b1;
        repeat (4) step();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_ifid_valid", 32'(if_id_valid), 32'd1);
        chk("stall_ifid_pc", if_id_pc, 32'h128);
        dir_stall = 1'b0;
        step();
        chk("stall_hold_pc", if_id_pc, 32'h128);
        step();
        chk("skid_ifid_pc", if_id_pc, 32'h12C);
        chk("skid_ifid_instr", if_id_instr, mem_word(32'h12C));

        // Redirect while waiting on a late response.
        lat_force = 3;
        step();
        chk("late_pend", 32'(pend), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        lat_force = 0;
        chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
        n = 0;
        while (!imem_req_valid && n < 20) begin
            chk("flush_ifid_valid", 32'(if_id_valid), 32'd0);
            step();
            n++;
        end
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_addr", imem_req_addr, 32'h200);
        n = 0;
        while (!if_id_valid && n < 20) begin
            step();
            n++;
        end
        chk("redir_ifid_valid", 32'(if_id_valid), 32'd1);
        chk("redir_ifid_pc", if_id_pc, 32'h200);

        // Redirect coinciding with a response.
        n = 0;
        while (!imem_rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("same_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        chk("same_req_valid", 32'(imem_req_valid), 32'd1);
        chk("same_req_addr", imem_req_addr, 32'h300);
        chk("same_ifid_valid", 32'(if_id_valid), 32'd0);

        // PC wrap.
        redirect_idle(32'hFFFF_FFFC);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_next_addr", imem_req_addr, 32'h0);

        // JAL predecode.
        redirect_idle(32'h40);
        chk("jal_req_addr", imem_req_addr, 32'h40);
        step();
        step();
        chk("jal_next_addr", imem_req_addr, PRED_EN ? 32'h50 : 32'h44);
        chk("jal_ifid_pc", if_id_pc, 32'h40);
        chk("jal_pred", 32'(if_id_pred_taken), 32'(PRED_EN));

        rnd = 1'b1;
        lat_force = -1;
        repeat (3000) step();
        rnd = 1'b0;
        repeat (5) step();

        // Asynchronous reset mid-operation.
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_addr", imem_req_addr, RST_PC);
        chk("mid_rst_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("mid_rst_ifid_pc", if_id_pc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
